seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 4-bit "1011" detector.
- Adds a configurable pattern length, a runtime-loadable pattern, an input-valid qualifier, overlap/non-overlap mode, and a saturating match counter.
- Sits on a serial bit stream in the digital-circuits sequential library and flags each occurrence of the programmed pattern.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..32).
- PATTERN, 4'b1011, reset/default pattern, PAT_LEN bits wide; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies `in`; a bit is consumed only when in_valid=1.
- in  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- pat_load  input  1  loads pat_in as the active pattern.
- pat_in  input  PAT_LEN  new pattern; MSB is the first bit received.
- cnt_clr  input  1  clears match_cnt.
- match  output  1  one-cycle pulse per detected pattern.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- State:
  - hist[PAT_LEN-1:0]: shift history, newest bit at LSB.
  - fill: 0..PAT_LEN, the number of valid bits eligible for the next match.
  - pat[PAT_LEN-1:0]: active pattern.
- Reset (rst=1 at the clock edge):
  - hist=0, fill=0, pat=PATTERN, match=0, match_cnt=0.
  - rst overrides every other input, including mid-pattern; any partial match is discarded.
- Consume (in_valid=1, pat_load=0):
  - hist_n = {hist[PAT_LEN-2:0], in}
  - fill_n = min(fill+1, PAT_LEN)
- Hit condition: hist_n == pat and fill_n == PAT_LEN.
- match timing:
  - Registered; goes high in the cycle after the edge that samples the completing bit. Latency is 1 clock.
  - High for exactly one cycle per hit.
  - 0 in any cycle whose preceding edge had in_valid=0.
- On a hit:
  - overlap_en=1: fill stays PAT_LEN, so the suffix of the hit can start the next match.
  - overlap_en=0: fill is set to 0 (hist still shifts), so the next PAT_LEN bits must be entirely new.
- in_valid=0: hist and fill hold; no match; gaps of any length do not break a partial pattern.
- overlap_en is sampled at each consuming edge. A change takes effect from the next consumed bit; there is no retroactive effect.
- pat_load=1:
  - pat=pat_in, hist=0, fill=0, match=0 next cycle.
  - in_valid in the same cycle is ignored (the bit is dropped).
  - match_cnt is unaffected.
- match_cnt:
  - +1 on each hit; saturates at all-ones and never wraps.
- cnt_clr:
  - cnt_clr=1 without a hit: match_cnt=0 next cycle.
  - cnt_clr=1 with a hit at the same edge: match_cnt=1.
  - cnt_clr does not affect match, hist, fill, or pat.
- Priority: rst > pat_load > consume.
- No combinational path from any input to any output.

Test Plan:
1. Defaults, overlap_en=1, rst released, stream 1,0,1,1,0,1,1 (in_valid=1 throughout) -> match pulses in the cycle after bit 4 and after bit 7; match_cnt=2.
2. Same stream with overlap_en=0 -> single pulse after bit 4; match_cnt=1. Appending 0,1,1 gives a second pulse after bit 10 (bits 7–10 = 1,0,1,1).
3. Stream 1,0,1,1 with in_valid=0 for 3 cycles between each bit -> exactly one pulse, one cycle after the edge sampling the final 1; no pulses during gaps.
4. pat_load with pat_in=4'b1111, then eight 1s, overlap_en=1 -> pulses after bits 4,5,6,7,8 (5 pulses). With overlap_en=0 -> pulses after bits 4 and 8 only. A bit presented in the load cycle is not counted.
5. CNT_W=2, overlap_en=1, ten consecutive 1s with pattern 1111 -> match_cnt reaches 3 and holds (7 pulses observed). Asserting cnt_clr at the same edge as a hit gives match_cnt=1.
6. rst asserted after 1,0,1 of a 1011 sequence, then released, then 1 -> no match. pat returns to 1011; match and match_cnt are 0 in the cycle following reset.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: flags each occurrence of a loadable
// PAT_LEN-bit pattern on a qualified bit stream and keeps a saturating count.
module seq_detect_param #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned     FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]   FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] pat;
  logic [FW-1:0]      fill;

  logic [PAT_LEN-1:0] hist_n;
  logic [FW-1:0]      fill_inc;
  logic               consume;
  logic               hit;

  always_comb begin
    hist_n   = {hist[PAT_LEN-2:0], in};
    fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
    consume  = in_valid && !pat_load;
    hit      = consume && (hist_n == pat) && (fill_inc == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= PATTERN;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= hit;

      if (pat_load) begin
        pat  <= pat_in;
        hist <= '0;
        fill <= '0;
      end else if (in_valid) begin
        hist <= hist_n;
        // Non-overlap restarts the fill so the next hit needs PAT_LEN fresh bits.
        fill <= (hit && !overlap_en) ? '0 : fill_inc;
      end

      if (cnt_clr)
        match_cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default instance (CNT_W=8) and a
// CNT_W=2 instance share stimulus so counter saturation is checked alongside.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       overlap_en = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = '0;
  logic       cnt_clr = 1'b0;

  logic       match_a, match_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match_a), .match_cnt(cnt_a)
  );

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match_b), .match_cnt(cnt_b)
  );

  typedef struct {
    logic        r, v, b, ov, ld;
    logic [3:0]  pin;
    logic        clr, em;
    int unsigned ec;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, v, b, ov, ld, input logic [3:0] pin,
                     input logic clr, em, input int unsigned ec, input string nm);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.ov = ov; t.ld = ld; t.pin = pin;
    t.clr = clr; t.em = em; t.ec = ec; t.nm = nm;
    tbl.push_back(t);
  endtask

  task automatic addb(input logic b, ov, em, input int unsigned ec, input string nm);
    add(1'b0, 1'b1, b, ov, 1'b0, 4'h0, 1'b0, em, ec, nm);
  endtask

  task automatic check(input string nm, input string what, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s %s: got %0d expected %0d", nm, what, act, exp);
  endtask

  // Drive one cycle, then sample both instances 1 ns after the edge.
  task automatic step(input logic r, v, b, ov, ld, input logic [3:0] pin,
                      input logic clr, em, input int unsigned ec, input string nm);
    int unsigned ec2;
    rst = r; in_valid = v; in = b; overlap_en = ov; pat_load = ld;
    pat_in = pin; cnt_clr = clr;
    @(posedge clk);
    #1;
    ec2 = (ec > 3) ? 3 : ec;
    check(nm, "match",      int'(match_a), int'(em));
    check(nm, "match_cnt",  int'(cnt_a),   int'(ec));
    check(nm, "match2",     int'(match_b), int'(em));
    check(nm, "match_cnt2", int'(cnt_b),   int'(ec2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  s2;
    logic [3:0]  p;

    #1;
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, "reset");

    // Overlapping, stream 1011011
    addb(1, 1, 0, 0, "t1_b1"); addb(0, 1, 0, 0, "t1_b2");
    addb(1, 1, 0, 0, "t1_b3"); addb(1, 1, 1, 1, "t1_b4");
    addb(0, 1, 0, 1, "t1_b5"); addb(1, 1, 0, 1, "t1_b6");
    addb(1, 1, 1, 2, "t1_b7");

    // Non-overlapping, stream 1011011011
    add(1, 1, 1, 0, 0, 4'h0, 0, 0, 0, "t2_rst");
    s2 = 10'b1011011011;
    for (int i = 0; i < 10; i++)
      addb(s2[9-i], 0, (i == 3 || i == 9), (i < 3) ? 0 : (i < 9) ? 1 : 2, $sformatf("t2_b%0d", i + 1));

    // Pattern 1111: load-cycle bit dropped, overlap then non-overlap
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, "t4_rst");
    add(0, 1, 1, 1, 1, 4'hF, 0, 0, 0, "t4_load");
    for (int i = 0; i < 8; i++)
      addb(1, 1, (i >= 3), (i < 3) ? 0 : i - 2, $sformatf("t4_ov_b%0d", i + 1));
    add(0, 1, 1, 0, 1, 4'hF, 0, 0, 5, "t4_reload");
    for (int i = 0; i < 8; i++)
      addb(1, 0, (i == 3 || i == 7), (i < 3) ? 5 : (i < 7) ? 6 : 7, $sformatf("t4_nov_b%0d", i + 1));

    // Ten 1s on 1111: 7 hits, CNT_W=2 instance saturates at 3; then cnt_clr
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, "t5_rst");
    add(0, 0, 0, 1, 1, 4'hF, 0, 0, 0, "t5_load");
    for (int i = 0; i < 10; i++)
      addb(1, 1, (i >= 3), (i < 3) ? 0 : i - 2, $sformatf("t5_b%0d", i + 1));
    add(0, 1, 1, 1, 0, 4'h0, 1, 1, 1, "t5_clr_hit");
    add(0, 0, 0, 1, 0, 4'h0, 1, 0, 0, "t5_clr");

    foreach (tbl[k])
      step(tbl[k].r, tbl[k].v, tbl[k].b, tbl[k].ov, tbl[k].ld, tbl[k].pin,
           tbl[k].clr, tbl[k].em, tbl[k].ec, tbl[k].nm);

    // Gapped 1011: three idle cycles after every bit (in toggled while idle)
    step(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, "t3_rst");
    p = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, p[3-i], 1, 0, 4'h0, 0, (i == 3), (i == 3), $sformatf("t3_b%0d", i + 1));
      for (int g = 0; g < 3; g++)
        step(0, 0, ~p[3-i], 1, 0, 4'h0, 0, 0, (i == 3), $sformatf("t3_gap%0d_%0d", i + 1, g));
    end

    // Reset mid-pattern restores pattern 1011 and discards partial history
    step(0, 0, 0, 1, 1, 4'hF, 0, 0, 1, "t6_load");
    step(0, 1, 1, 1, 0, 4'h0, 0, 0, 1, "t6_b1");
    step(0, 1, 0, 1, 0, 4'h0, 0, 0, 1, "t6_b2");
    step(0, 1, 1, 1, 0, 4'h0, 0, 0, 1, "t6_b3");
    step(1, 1, 1, 1, 0, 4'h0, 1, 0, 0, "t6_rst");
    step(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, "t6_after1");
    step(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, "t6_after2");
    step(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, "t6_after3");
    step(0, 1, 1, 1, 0, 4'h0, 0, 1, 1, "t6_after4");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
